// File: rtl/exec_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute handshake and write-back.
// Handshake: imem_req stays high in FETCH until imem_valid is seen; rf read data arrives one cycle after the address.
module exec_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  rf_rs1_addr,
  output logic [4:0]  rf_rs2_addr,
  input  logic [31:0] rf_rs1_data,
  input  logic [31:0] rf_rs2_data,
  output logic        rf_we,
  output logic [4:0]  rf_rd_addr,
  output logic [31:0] rf_wdata,
  output logic [6:0]  ex_opcode,
  output logic [3:0]  ex_func,
  output logic [31:0] ex_imm,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  input  logic [31:0] ex_sonuc,
  input  logic        ex_pc_update,
  input  logic        ex_we,
  output logic [31:0] pc,
  output logic        busy,
  output logic        halted,
  output logic [1:0]  err,
  output logic [15:0] retired,
  output logic [2:0]  dbg_state
);

  localparam logic [6:0] OP_R    = 7'b0000001;
  localparam logic [6:0] OP_I    = 7'b0000011;
  localparam logic [6:0] OP_U    = 7'b0000111;
  localparam logic [6:0] OP_B    = 7'b0001111;
  localparam logic [6:0] OP_HALT = 7'b1111111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  err_q, err_d;
  logic [15:0] retired_q, retired_d;
  logic [31:0] instr_q, instr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] sonuc_q, sonuc_d;
  logic        we_q, we_d;
  logic        pcupd_q, pcupd_d;

  logic [6:0]  op_w;
  logic [4:0]  rd_w;
  logic [31:0] boff_w;
  logic [31:0] imm_w;

  assign op_w   = instr_q[6:0];
  assign rd_w   = instr_q[11:7];
  assign boff_w = {{21{instr_q[31]}}, instr_q[31:26], instr_q[11:7]};

  always_comb begin
    case (op_w)
      OP_I:    imm_w = {{21{instr_q[31]}}, instr_q[31:21]};
      OP_U:    imm_w = {12'b0, instr_q[31:12]};
      OP_B:    imm_w = boff_w;
      default: imm_w = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      err_q     <= 2'b00;
      retired_q <= 16'h0;
      instr_q   <= 32'h0;
      cnt_q     <= 16'h0;
      sonuc_q   <= 32'h0;
      we_q      <= 1'b0;
      pcupd_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      err_q     <= err_d;
      retired_q <= retired_d;
      instr_q   <= instr_d;
      cnt_q     <= cnt_d;
      sonuc_q   <= sonuc_d;
      we_q      <= we_d;
      pcupd_q   <= pcupd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    err_d       = err_q;
    retired_d   = retired_q;
    instr_d     = instr_q;
    cnt_d       = cnt_q;
    sonuc_d     = sonuc_q;
    we_d        = we_q;
    pcupd_d     = pcupd_q;
    ex_opcode   = 7'h0;
    ex_func     = 4'h0;
    ex_imm      = 32'h0;
    ex_rs1_data = 32'h0;
    ex_rs2_data = 32'h0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          cnt_d   = 16'h0;
        end
      end
      FETCH: begin
        // A valid in the last allowed wait cycle still wins over the timeout.
        if (imem_valid) begin
          instr_d = imem_rdata;
          state_d = DECODE;
        end else if (({16'h0, cnt_q} + 32'd1) >= FETCH_TIMEOUT) begin
          state_d = HALT;
          err_d   = 2'b10;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DECODE: begin
        case (op_w)
          OP_HALT:                 state_d = HALT;
          OP_R, OP_I, OP_U, OP_B:  state_d = EXEC;
          default: begin
            state_d = HALT;
            err_d   = 2'b01;
          end
        endcase
      end
      EXEC: begin
        ex_opcode   = op_w;
        ex_func     = instr_q[15:12];
        ex_imm      = imm_w;
        ex_rs1_data = rf_rs1_data;
        ex_rs2_data = rf_rs2_data;
        sonuc_d     = ex_sonuc;
        we_d        = ex_we;
        pcupd_d     = ex_pc_update;
        state_d     = WB;
      end
      WB: begin
        pc_d      = pcupd_q ? (pc_q + (boff_w << 2)) : (pc_q + 32'd4);
        retired_d = retired_q + 16'd1;
        cnt_d     = 16'h0;
        state_d   = FETCH;
      end
      HALT: ;
      default: state_d = IDLE;
    endcase
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign rf_rs1_addr = instr_q[20:16];
  assign rf_rs2_addr = instr_q[25:21];
  assign rf_we       = (state_q == WB) && we_q && (rd_w != 5'd0);
  assign rf_rd_addr  = rd_w;
  assign rf_wdata    = sonuc_q;
  assign pc          = pc_q;
  assign busy        = (state_q != IDLE) && (state_q != HALT);
  assign halted      = (state_q == HALT);
  assign err         = err_q;
  assign retired     = retired_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: register-file and execute-unit models, a table-driven program,
// and hand-written sequences for timeout, illegal opcode, halt and reset-in-write-back.
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        rf_we;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_wdata;
  logic [6:0]  ex_opcode;
  logic [3:0]  ex_func;
  logic [31:0] ex_imm, ex_rs1_data, ex_rs2_data;
  logic [31:0] ex_sonuc;
  logic        ex_pc_update, ex_we;
  logic [31:0] pc;
  logic        busy, halted;
  logic [1:0]  err;
  logic [15:0] retired;
  logic [2:0]  dbg_state;

  int pass_cnt = 0;
  int total_cnt = 0;
  int we_cnt = 0;

  exec_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_wdata(rf_wdata),
    .ex_opcode(ex_opcode), .ex_func(ex_func), .ex_imm(ex_imm),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_sonuc(ex_sonuc), .ex_pc_update(ex_pc_update), .ex_we(ex_we),
    .pc(pc), .busy(busy), .halted(halted), .err(err), .retired(retired),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // register file model with registered reads; r1=5 r2=7 r4=5 r5=5 after each reset
  logic [31:0] regs [32];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
      regs[1] <= 32'd5;
      regs[2] <= 32'd7;
      regs[4] <= 32'd5;
      regs[5] <= 32'd5;
    end else if (rf_we) begin
      regs[rf_rd_addr] <= rf_wdata;
    end
    rf_rs1_data <= (rf_rs1_addr == 5'd0) ? 32'h0 : regs[rf_rs1_addr];
    rf_rs2_data <= (rf_rs2_addr == 5'd0) ? 32'h0 : regs[rf_rs2_addr];
  end

  // execute-unit model: ADD, ADDI, U-load, BEQ
  always_comb begin
    ex_sonuc     = 32'h0;
    ex_we        = 1'b0;
    ex_pc_update = 1'b0;
    case (ex_opcode)
      7'h01: begin ex_sonuc = ex_rs1_data + ex_rs2_data; ex_we = 1'b1; end
      7'h03: begin ex_sonuc = ex_rs1_data + ex_imm;      ex_we = 1'b1; end
      7'h07: begin ex_sonuc = ex_imm;                    ex_we = 1'b1; end
      7'h0F: ex_pc_update = (ex_rs1_data == ex_rs2_data);
      default: ;
    endcase
  end

  always @(posedge clk) if (rf_we === 1'b1) we_cnt <= we_cnt + 1;

  // instruction encoders
  function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {6'b0, rs2, rs1, 4'h0, rd, 7'b0000001};
  endfunction
  function automatic logic [31:0] mk_i(input logic [4:0] rd, input logic [4:0] rs1, input logic [10:0] imm);
    return {imm, rs1, 4'h0, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] mk_u(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'b0000111};
  endfunction
  function automatic logic [31:0] mk_b(input logic [4:0] rs1, input logic [4:0] rs2, input logic [10:0] off);
    return {off[10:5], rs2, rs1, 4'h0, off[4:0], 7'b0001111};
  endfunction

  // scoreboard check
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (!imem_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!imem_req) chk({name, "_req_wait"}, 32'(imem_req), 32'h1);
  endtask

  task automatic give_instr(input logic [31:0] instr);
    imem_valid = 1'b1;
    imem_rdata = instr;
    @(posedge clk);
    #1;
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_wdata;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [7];

  // one instruction: FETCH (valid at once), DECODE, EXEC, WB, then back in FETCH
  task automatic run_vec(input vec_t v, input int idx);
    int w0;
    string tag;
    tag = $sformatf("v%0d", idx);
    wait_req(tag);
    chk({tag, "_imem_addr"}, imem_addr, v.exp_addr);
    give_instr(v.instr);
    w0 = we_cnt;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_rf_we"}, 32'(rf_we), 32'(v.exp_we));
    if (v.exp_we) begin
      chk({tag, "_rd"}, 32'(rf_rd_addr), 32'(v.exp_rd));
      chk({tag, "_wdata"}, rf_wdata, v.exp_wdata);
    end
    @(negedge clk);
    chk({tag, "_refetch_4cyc"}, 32'(imem_req), 32'h1);
    chk({tag, "_pc"}, pc, v.exp_pc);
    chk({tag, "_retired"}, 32'(retired), 32'(idx + 1));
    chk({tag, "_we_pulses"}, 32'(we_cnt - w0), 32'(v.exp_we));
  endtask

  initial begin
    int w0;
    int n;
    vecs[0] = '{mk_r(5'd3, 5'd1, 5'd2),       32'h00, 1'b1, 5'd3, 32'd12,        32'h04};
    vecs[1] = '{mk_i(5'd0, 5'd1, 11'd3),      32'h04, 1'b0, 5'd0, 32'd0,         32'h08};
    vecs[2] = '{mk_u(5'd6, 20'h12345),        32'h08, 1'b1, 5'd6, 32'h0001_2345, 32'h0C};
    vecs[3] = '{mk_i(5'd7, 5'd1, 11'h7FF),    32'h0C, 1'b1, 5'd7, 32'd4,         32'h10};
    vecs[4] = '{mk_b(5'd4, 5'd5, 11'h7FE),    32'h10, 1'b0, 5'd0, 32'd0,         32'h08};
    vecs[5] = '{mk_b(5'd1, 5'd2, 11'h7FE),    32'h08, 1'b0, 5'd0, 32'd0,         32'h0C};
    vecs[6] = '{mk_r(5'd8, 5'd3, 5'd7),       32'h0C, 1'b1, 5'd8, 32'd16,        32'h10};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_retired", 32'(retired), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_imem_req", 32'(imem_req), 32'h0);
    chk("rst_rf_we", 32'(rf_we), 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_without_start", 32'(busy), 32'h0);

    // program table
    pulse_start();
    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // HALT instruction: no retire, no write, pc holds; HALT absorbs start and stray valid
    chk("halt_addr", imem_addr, 32'h10);
    w0 = we_cnt;
    give_instr(32'h0000_007F);
    @(negedge clk);
    @(negedge clk);
    chk("halt_halted", 32'(halted), 32'h1);
    chk("halt_err", 32'(err), 32'h0);
    chk("halt_retired", 32'(retired), 32'd7);
    chk("halt_pc", pc, 32'h10);
    chk("halt_busy", 32'(busy), 32'h0);
    start = 1'b1;
    imem_valid = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    imem_valid = 1'b0;
    chk("halt_absorb", 32'(halted), 32'h1);
    chk("halt_no_req", 32'(imem_req), 32'h0);
    chk("halt_pc_hold", pc, 32'h10);
    chk("halt_no_we", 32'(we_cnt - w0), 32'h0);

    // fetch timeout: 15 FETCH cycles with no valid, then HALT with err=10
    do_reset();
    pulse_start();
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!imem_req) break;
      n++;
    end
    chk("to_fetch_cycles", 32'(n), 32'd15);
    chk("to_halted", 32'(halted), 32'h1);
    chk("to_err", 32'(err), 32'h2);
    chk("to_req_dropped", 32'(imem_req), 32'h0);

    // illegal opcode, then reset back to IDLE
    do_reset();
    pulse_start();
    wait_req("ill");
    give_instr(32'h0000_0000);
    @(negedge clk);
    @(negedge clk);
    chk("ill_halted", 32'(halted), 32'h1);
    chk("ill_err", 32'(err), 32'h1);
    chk("ill_retired", 32'(retired), 32'h0);
    chk("ill_pc", pc, 32'h0);
    do_reset();
    @(negedge clk);
    chk("ill_rst_pc", pc, 32'h0);
    chk("ill_rst_state", 32'(dbg_state), 32'd0);
    chk("ill_rst_err", 32'(err), 32'h0);
    chk("ill_rst_halted", 32'(halted), 32'h0);

    // reset on the edge that would enter WB: the pending write must not happen
    do_reset();
    pulse_start();
    run_vec(vecs[0], 0);
    give_instr(mk_r(5'd9, 5'd1, 5'd2));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    w0 = we_cnt;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rwb_rf_we", 32'(rf_we), 32'h0);
    chk("rwb_pc", pc, 32'h0);
    chk("rwb_retired", 32'(retired), 32'h0);
    chk("rwb_busy", 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    chk("rwb_no_write", 32'(we_cnt - w0), 32'h0);

    // final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
